// File: rtl/except_redirect_ctrl.sv
// Exception/ERET redirect sequencer for the uncached instruction fetch path.
// Latency: redirect one cycle after flush (no fetches pending) or one cycle after the last pending response.
// Backpressure: masks fetch requests while flushing/draining or when MAX_OUTSTANDING fetches are in flight.
// Optional feature macro: EXC_FAST_REDIRECT_EN (same-cycle redirect from IDLE when nothing is in flight).
module except_redirect_ctrl #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_except,
  input  logic [31:0] pc_except,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  output logic        inst_req_mask,
  output logic        discard_inst,
  output logic        flushF,
  output logic        flushD,
  output logic        flushE,
  output logic        flushM,
  output logic        stallF,
  output logic        pc_redirect_valid,
  output logic [31:0] pc_redirect,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DRAIN    = 2'd1,
    S_REDIRECT = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [31:0]      target_q;
  logic             cnt_inc;
  logic             cnt_dec;
  logic             fast_hit;

  // Outstanding-fetch count: a response with nothing in flight is ignored, and the count saturates at MAX.
  always_comb begin
    cnt_dec = inst_data_ok && (cnt_q != '0);
    cnt_inc = inst_addr_ok && ((cnt_q != CNT_MAX) || cnt_dec);
    cnt_d   = cnt_q;
    if (cnt_inc && !cnt_dec) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!cnt_inc && cnt_dec) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

`ifdef EXC_FAST_REDIRECT_EN
  // Nothing in flight after this cycle: redirect immediately and stay in IDLE.
  assign fast_hit = (state_q == S_IDLE) && flush_except && (cnt_d == '0);
`else
  assign fast_hit = 1'b0;
`endif

  // Sequencer state, outstanding counter and latched redirect target.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      target_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        S_IDLE: begin
          if (flush_except) begin
            target_q <= pc_except;
            if (fast_hit) begin
              state_q <= S_IDLE;
            end else if (cnt_d == '0) begin
              state_q <= S_REDIRECT;
            end else begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // A second flush here is ignored: the pipeline only holds bubbles.
          if (cnt_d == '0) begin
            state_q <= S_REDIRECT;
          end
        end
        S_REDIRECT: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Flush, stall, mask and redirect outputs decoded from state, flush_except and the counter.
  always_comb begin
    inst_req_mask     = (cnt_q == CNT_MAX);
    discard_inst      = 1'b0;
    flushF            = 1'b0;
    flushD            = 1'b0;
    flushE            = 1'b0;
    flushM            = 1'b0;
    stallF            = 1'b0;
    pc_redirect_valid = 1'b0;
    pc_redirect       = '0;
    busy              = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (flush_except) begin
          inst_req_mask = 1'b1;
          flushF        = 1'b1;
          flushD        = 1'b1;
          flushE        = 1'b1;
          flushM        = 1'b1;
        end
        if (fast_hit) begin
          pc_redirect_valid = 1'b1;
          pc_redirect       = pc_except;
        end
      end
      S_DRAIN: begin
        inst_req_mask = 1'b1;
        stallF        = 1'b1;
        flushF        = 1'b1;
        flushD        = 1'b1;
        flushE        = 1'b1;
        flushM        = 1'b1;
        discard_inst  = inst_data_ok;
      end
      S_REDIRECT: begin
        inst_req_mask     = 1'b1;
        flushF            = 1'b1;
        flushD            = 1'b1;
        pc_redirect_valid = 1'b1;
        pc_redirect       = target_q;
      end
      default: begin
        inst_req_mask = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_except_redirect_ctrl.sv
// Self-checking bench for except_redirect_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_except_redirect_ctrl;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_except = 1'b0;
  logic [31:0] pc_except = '0;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic        inst_req_mask, discard_inst, flushF, flushD, flushE, flushM, stallF;
  logic        pc_redirect_valid, busy;
  logic [31:0] pc_redirect;

  int tests = 0;
  int fails = 0;

  except_redirect_ctrl #(.MAX_OUTSTANDING(MAXO), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .flush_except(flush_except), .pc_except(pc_except),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_req_mask(inst_req_mask), .discard_inst(discard_inst),
    .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .stallF(stallF), .pc_redirect_valid(pc_redirect_valid),
    .pc_redirect(pc_redirect), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: phase 0 = normal fetching, 1 = waiting for squashed fetches, 2 = redirect cycle.
  int          m_phase = 0;
  int          m_pending = 0;
  logic [31:0] m_target = '0;
  int          m_next_pending = 0;
  bit          m_fast = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and compare every output against the model.
  task automatic apply(input bit r, input bit f, input logic [31:0] pc, input bit a, input bit d);
    bit          flushing, e_mask, e_fF, e_fE, e_valid;
    logic [31:0] e_pc;
    @(negedge clk);
    rst = r; flush_except = f; pc_except = pc; inst_addr_ok = a; inst_data_ok = d;
    #1;
    m_next_pending = m_pending + int'(a) - ((d && m_pending > 0) ? 1 : 0);
    if (m_next_pending > MAXO) m_next_pending = MAXO;
    flushing = (m_phase == 0) && f;
`ifdef EXC_FAST_REDIRECT_EN
    m_fast = flushing && (m_next_pending == 0);
`else
    m_fast = 1'b0;
`endif
    e_mask  = (m_phase != 0) || flushing || (m_pending == MAXO);
    e_fF    = (m_phase != 0) || flushing;
    e_fE    = (m_phase == 1) || flushing;
    e_valid = (m_phase == 2) || m_fast;
    e_pc    = (m_phase == 2) ? m_target : (m_fast ? pc : 32'h0);
    chk("inst_req_mask", {31'b0, inst_req_mask}, {31'b0, e_mask});
    chk("discard_inst", {31'b0, discard_inst}, {31'b0, (m_phase == 1) && d});
    chk("flushF", {31'b0, flushF}, {31'b0, e_fF});
    chk("flushD", {31'b0, flushD}, {31'b0, e_fF});
    chk("flushE", {31'b0, flushE}, {31'b0, e_fE});
    chk("flushM", {31'b0, flushM}, {31'b0, e_fE});
    chk("stallF", {31'b0, stallF}, {31'b0, m_phase == 1});
    chk("pc_redirect_valid", {31'b0, pc_redirect_valid}, {31'b0, e_valid});
    chk("pc_redirect", pc_redirect, e_pc);
    chk("busy", {31'b0, busy}, {31'b0, m_phase != 0});
  endtask

  // Clock edge: move the model forward using the inputs applied this cycle.
  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_phase = 0; m_pending = 0; m_target = '0;
    end else begin
      if (m_phase == 0 && flush_except) begin
        m_target = pc_except;
        if (m_fast) m_phase = 0;
        else m_phase = (m_next_pending == 0) ? 2 : 1;
      end else if (m_phase == 1) begin
        if (m_next_pending == 0) m_phase = 2;
      end else if (m_phase == 2) begin
        m_phase = 0;
      end
      m_pending = m_next_pending;
    end
  endtask

  task automatic step(input bit r, input bit f, input logic [31:0] pc, input bit a, input bit d);
    apply(r, f, pc, a, d);
    advance();
  endtask

  int discards;

  initial begin
    // Reset: DUT state is unknown before the first edge, so no comparison yet.
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state: all outputs low.
    apply(0, 0, 32'h0, 0, 0);
    chk("reset_mask", {31'b0, inst_req_mask}, 32'h0);
    chk("reset_valid", {31'b0, pc_redirect_valid}, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    advance();

    // Idle exception with nothing in flight.
    apply(0, 1, 32'hBFC00380, 0, 0);
    chk("s1_flushM_t", {31'b0, flushM}, 32'h1);
    chk("s1_mask_t", {31'b0, inst_req_mask}, 32'h1);
`ifdef EXC_FAST_REDIRECT_EN
    chk("s1_fast_valid_t", {31'b0, pc_redirect_valid}, 32'h1);
    chk("s1_fast_pc_t", pc_redirect, 32'hBFC00380);
    advance();
    apply(0, 0, 32'h0, 0, 0);
    chk("s1_fast_busy_t1", {31'b0, busy}, 32'h0);
    advance();
`else
    advance();
    apply(0, 0, 32'h0, 0, 0);
    chk("s1_valid_t1", {31'b0, pc_redirect_valid}, 32'h1);
    chk("s1_pc_t1", pc_redirect, 32'hBFC00380);
    advance();
    apply(0, 0, 32'h0, 0, 0);
    chk("s1_busy_t2", {31'b0, busy}, 32'h0);
    advance();
`endif

    // One pending fetch, answered at t+3.
    step(0, 0, 32'h0, 1, 0);
    step(0, 1, 32'hBFC00380, 0, 0);
    apply(0, 0, 32'h0, 0, 0);
    chk("s2_stall_t1", {31'b0, stallF}, 32'h1);
    advance();
    apply(0, 0, 32'h0, 0, 0);
    chk("s2_stall_t2", {31'b0, stallF}, 32'h1);
    advance();
    apply(0, 0, 32'h0, 0, 1);
    chk("s2_discard_t3", {31'b0, discard_inst}, 32'h1);
    chk("s2_stall_t3", {31'b0, stallF}, 32'h1);
    advance();
    apply(0, 0, 32'h0, 0, 0);
    chk("s2_valid_t4", {31'b0, pc_redirect_valid}, 32'h1);
    chk("s2_stall_t4", {31'b0, stallF}, 32'h0);
    advance();

    // ERET with two pending plus a late accept; second flush in DRAIN is ignored.
    step(0, 0, 32'h0, 1, 0);
    step(0, 0, 32'h0, 1, 0);
    discards = 0;
    apply(0, 1, 32'h80001234, 0, 0); advance();
    apply(0, 0, 32'h0, 1, 1); discards += int'(discard_inst); advance();
    apply(0, 0, 32'h0, 0, 1); discards += int'(discard_inst); advance();
    apply(0, 1, 32'h12345678, 0, 0); discards += int'(discard_inst); advance();
    apply(0, 0, 32'h0, 0, 1); discards += int'(discard_inst);
    chk("s3_no_valid_t4", {31'b0, pc_redirect_valid}, 32'h0);
    advance();
    apply(0, 0, 32'h0, 0, 0);
    chk("s3_valid_t5", {31'b0, pc_redirect_valid}, 32'h1);
    chk("s3_eret_pc", pc_redirect, 32'h80001234);
    advance();
    chk("s3_discards", discards, 32'd3);

    // Reset in the middle of a drain.
    step(0, 0, 32'h0, 1, 0);
    step(0, 1, 32'hBFC00380, 0, 0);
    step(1, 0, 32'h0, 0, 0);
    apply(0, 0, 32'h0, 0, 0);
    chk("s4_busy", {31'b0, busy}, 32'h0);
    chk("s4_mask", {31'b0, inst_req_mask}, 32'h0);
    chk("s4_stall", {31'b0, stallF}, 32'h0);
    advance();
    // Counter must be zero again: a flush now goes straight to redirect.
    apply(0, 1, 32'hBFC00380, 0, 0);
`ifdef EXC_FAST_REDIRECT_EN
    chk("s4_fast_valid", {31'b0, pc_redirect_valid}, 32'h1);
    advance();
`else
    advance();
    apply(0, 0, 32'h0, 0, 0);
    chk("s4_valid", {31'b0, pc_redirect_valid}, 32'h1);
    advance();
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bit r, f, a, d, masked;
      logic [31:0] pc;
      masked = (m_phase != 0) || (m_pending == MAXO);
      r  = ($urandom_range(0, 199) == 0);
      f  = ($urandom_range(0, 7) == 0);
      pc = $urandom();
      a  = masked ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) == 0);
      d  = (m_pending > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
      step(r, f, pc, a, d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/except_redirect_ctrl.md
# except_redirect_ctrl

Sequences the pipeline redirect that follows an exception or ERET signalled by the MEM-stage exception unit, for the uncached SRAM-like/AXI instruction fetch path. The block flushes the pipeline and blocks new fetch requests. It drains and discards every instruction fetch still in flight, then issues a single registered PC redirect to the exception vector or EPC. It sits between the exception unit, the fetch-side SRAM-like interface and the PC register.

## Interface
Parameters:
- MAX_OUTSTANDING, default 2: maximum number of instruction fetches accepted but not yet answered.
- CNT_W, default 2: outstanding-counter width. Must satisfy 2^CNT_W > MAX_OUTSTANDING.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- flush_except  in  1  exception or ERET taken in MEM this cycle.
- pc_except  in  32  redirect target (vector 0xBFC00380 or EPC).
- inst_addr_ok  in  1  fetch request accepted this cycle.
- inst_data_ok  in  1  fetch response returned this cycle.
- inst_req_mask  out  1  forces the fetch request low.
- discard_inst  out  1  current inst_data_ok response is dropped and must not enter IF/ID.
- flushF, flushD, flushE, flushM  out  1 each  clear the corresponding pipeline register.
- stallF  out  1  holds the PC register.
- pc_redirect_valid  out  1  PC register loads pc_redirect this cycle.
- pc_redirect  out  32  redirect target.
- busy  out  1  state is not IDLE.

## Operation
- The outstanding counter cnt is updated every cycle as cnt + inst_addr_ok − inst_data_ok.
  - inst_addr_ok and inst_data_ok in the same cycle leave cnt unchanged.
  - inst_data_ok while cnt==0 is ignored; cnt stays 0.
  - cnt never exceeds MAX_OUTSTANDING.
  - cnt_next is the post-update value.
- The state machine has three states: IDLE, DRAIN, REDIRECT.
- IDLE:
  - When flush_except=1, latch pc_except into target.
  - Assert flushF/D/E/M and inst_req_mask combinationally in the same cycle.
  - If cnt_next==0, go to REDIRECT. Otherwise go to DRAIN.
- DRAIN:
  - inst_req_mask=1, stallF=1, flushF/D/E/M=1, discard_inst=inst_data_ok.
  - inst_addr_ok arriving here (handshake already in progress) is still counted and its response is discarded.
  - Go to REDIRECT when cnt_next==0.
- REDIRECT:
  - pc_redirect_valid=1, pc_redirect=target, flushF/D=1, inst_req_mask=1 for exactly one cycle.
  - Next state is IDLE.
- flush_except is ignored in DRAIN and REDIRECT. The pipeline holds only bubbles then, so no second exception is accepted.
- Outside redirect, inst_req_mask=1 whenever cnt==MAX_OUTSTANDING.
- ERET and exceptions are handled identically; only pc_except differs.

## Timing
- Reset:
  - state=IDLE, cnt=0, target=0.
  - All outputs 0, except inst_req_mask, which follows the rule above (0 at reset).
- Redirect latency:
  - Without outstanding fetches: flush at cycle t, pc_redirect_valid at t+1.
  - With N responses pending: pc_redirect_valid one cycle after the last pending inst_data_ok.
- Fetch to the new PC begins at the cycle after pc_redirect_valid.
- rst asserted mid-DRAIN returns the block to IDLE with cnt=0 the next cycle. Responses still pending are the fetch unit's concern.
- All state and counter updates happen on the rising edge of clk. Flush and mask outputs are combinational from state, flush_except and cnt.

## Configuration
- EXC_FAST_REDIRECT_EN:
  - Defined: in IDLE, if flush_except=1 and cnt_next==0, pc_redirect_valid=1 and pc_redirect=pc_except in the same cycle. The REDIRECT state is skipped and the machine stays IDLE.
  - Not defined: the redirect always passes through the registered REDIRECT state (latency ≥1 cycle).

## Test plan
- Idle exception: cnt=0, flush_except=1 with pc_except=0xBFC00380 at cycle t -> flushF..M=1 at t, pc_redirect_valid=1 with 0xBFC00380 at t+1, busy=0 at t+2.
- One pending fetch: cnt=1, flush_except at t, inst_data_ok at t+3 -> discard_inst=1 at t+3, redirect at t+4, stallF=1 over t+1..t+3.
- Two pending plus a late accept: cnt=2, flush at t, inst_addr_ok+inst_data_ok at t+1, inst_data_ok at t+2 and t+4 -> three responses discarded, redirect at t+5.
- ERET: pc_except=0x80001234 (EPC) -> pc_redirect=0x80001234; flush_except re-asserted during DRAIN has no effect on target.
- Reset mid-DRAIN: rst at t+1 -> at t+2 state IDLE, cnt=0, all outputs 0.
- Build with EXC_FAST_REDIRECT_EN: flush with cnt=0 -> pc_redirect_valid in the same cycle, busy never asserted.
